c499_key_ctrl: RTL

C499_KEY_CTRL -- requirements
Module: c499_key_ctrl

---
 rtl/c499_key_pkg.sv | 43 ++++
 rtl/c499_key_shreg.sv | 43 ++++
 rtl/c499_key_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/c499_key_pkg.sv
// Shared types and known-answer vectors for the c499 key controller.
// Vectors are {N137, N136..N129 check bits, N125..N1 data}.
package c499_key_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        APPLY   = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4,
        LOCKOUT = 3'd5
    } state_e;

    localparam int ECC_W   = 41;
    localparam int DATA_W  = 32;
    localparam int KAT_NUM = 4;

    // Vectors 0-2 are clean codewords; vector 3 is vector 0 with data bit 4 flipped.
    function automatic logic [ECC_W-1:0] kat_vec(input int unsigned idx);
        logic [ECC_W-1:0] v;
        case (idx)
            0:       v = {1'b1, 8'h00, 32'h0000_0000};
            1:       v = {1'b1, 8'h3C, 32'hFFFF_0000};
            2:       v = {1'b1, 8'hC3, 32'h1234_5678};
            3:       v = {1'b1, 8'h00, 32'h0000_0010};
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] kat_gold(input int unsigned idx);
        logic [DATA_W-1:0] g;
        case (idx)
            0:       g = 32'h0000_0000;
            1:       g = 32'hFFFF_0000;
            2:       g = 32'h1234_5678;
            3:       g = 32'h0000_0000;
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/c499_key_shreg.sv
// Serial key loader: LSB-first shift register with bit counter and full flag.
// data_nxt_o is the register contents after the current bit, so the caller can
// capture the whole key on the same edge that takes the last bit.
module c499_key_shreg #(
    parameter int KEY_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [KEY_W-1:0] data_nxt_o,
    output logic             last_o,
    output logic             full_o
);

    localparam int CW = $clog2(KEY_W + 1);

    logic [KEY_W-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    logic             full_q;

    assign data_nxt_o = {din, sr_q[KEY_W-1:1]};
    assign last_o     = shift_en && !full_q && (cnt_q == CW'(KEY_W - 1));
    assign full_o     = full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else if (clr) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else if (shift_en && !full_q) begin
            sr_q  <= data_nxt_o;
            cnt_q <= cnt_q + 1'b1;
            if (last_o) full_q <= 1'b1;
        end
    end

endmodule

// File: rtl/c499_key_ctrl.sv
// Key load and known-answer check controller for a key-locked c499 ECC block.
// Optional feature: define C499_KEY_LOCKOUT_EN to lock out after three failed checks.
module c499_key_ctrl
    import c499_key_pkg::*;
#(
    parameter int KEY_W   = 8,
    parameter int SETTLE  = 2,
    parameter int NUM_VEC = KAT_NUM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              key_sin,
    input  logic              key_sin_vld,
    output logic [KEY_W-1:0]  key_out,
    output logic [ECC_W-1:0]  ecc_din,
    input  logic [DATA_W-1:0] ecc_dout,
    output logic              busy,
    output logic              done,
    output logic              key_ok,
    output logic [1:0]        fail_cnt,
    output state_e            state_dbg
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int VW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

    state_e            state_q;
    logic [KEY_W-1:0]  key_out_q;
    logic [ECC_W-1:0]  ecc_din_q;
    logic [SW-1:0]     cnt_q;
    logic [VW-1:0]     vidx_q;
    logic              mis_q;
    logic              busy_q;
    logic              done_q;
    logic              key_ok_q;
    logic [1:0]        fail_cnt_q;

    logic              start_ok;
    logic              sh_en;
    logic              sh_last;
    logic              sh_full;
    logic [KEY_W-1:0]  sh_data;
    logic              cur_mis;
    logic              any_mis;

    // key_sin is taken on every rising edge where key_sin_vld is high while in SHIFT;
    // there is no back-pressure, and key_sin_vld in any other state is dropped.
    assign start_ok = start && (state_q == IDLE || state_q == DONE);
    assign sh_en    = key_sin_vld && (state_q == SHIFT) && !sh_full;
    assign cur_mis  = (ecc_dout != kat_gold(32'(vidx_q)));
    assign any_mis  = mis_q || cur_mis;

    c499_key_shreg #(.KEY_W(KEY_W)) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_ok),
        .shift_en   (sh_en),
        .din        (key_sin),
        .data_nxt_o (sh_data),
        .last_o     (sh_last),
        .full_o     (sh_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_out_q  <= '0;
            ecc_din_q  <= '0;
            cnt_q      <= '0;
            vidx_q     <= '0;
            mis_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            key_ok_q   <= 1'b0;
            fail_cnt_q <= 2'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q  <= SHIFT;
                        busy_q   <= 1'b1;
                        key_ok_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sh_last) begin
                        key_out_q <= sh_data;
                        cnt_q     <= '0;
                        state_q   <= APPLY;
                    end
                end
                APPLY: begin
                    if (cnt_q == SW'(SETTLE - 1)) begin
                        cnt_q     <= '0;
                        vidx_q    <= '0;
                        mis_q     <= 1'b0;
                        ecc_din_q <= kat_vec(0);
                        state_q   <= CHECK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (cnt_q == SW'(SETTLE)) begin
                        cnt_q <= '0;
                        if (vidx_q == VW'(NUM_VEC - 1)) begin
                            ecc_din_q <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            key_ok_q  <= !any_mis;
                            state_q   <= DONE;
                            if (!any_mis) begin
                                fail_cnt_q <= 2'd0;
                            end else begin
                                if (fail_cnt_q != 2'd3) fail_cnt_q <= fail_cnt_q + 2'd1;
`ifdef C499_KEY_LOCKOUT_EN
                                if (fail_cnt_q == 2'd2) begin
                                    key_out_q <= '0;
                                    state_q   <= LOCKOUT;
                                end
`endif
                            end
                        end else begin
                            vidx_q    <= vidx_q + 1'b1;
                            mis_q     <= any_mis;
                            ecc_din_q <= kat_vec(32'(vidx_q) + 32'd1);
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LOCKOUT: begin
                    state_q <= LOCKOUT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign key_out   = key_out_q;
    assign ecc_din   = ecc_din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign key_ok    = key_ok_q;
    assign fail_cnt  = fail_cnt_q;
    assign state_dbg = state_q;

endmodule
